reg_file_arbiter: RTL

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

---
 rtl/reg_arb_pkg.sv | 14 +
 rtl/reg_file.sv | 31 +++
 rtl/reg_file_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared widths and FSM state encoding for the two-port register-file arbiter.
package reg_arb_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 2;
    localparam int NUM_REG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        COOL  = 2'b10
    } state_t;

endpackage

// File: rtl/reg_file.sv
// NUM_REG x DATA_W storage: synchronous write, registered read, synchronous reset.
module reg_file #(
    parameter int DATA_W = reg_arb_pkg::DATA_W,
    parameter int ADDR_W = reg_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int NUM_REG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REG];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= '{default: '0};
            rdata <= '0;
        end else begin
            if (we)
                mem[addr] <= wdata;
            if (re)
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter giving two requesters one-cycle access to a shared register file,
// with a one-cycle cool-down bubble after every grant.
module reg_file_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = reg_arb_pkg::DATA_W,
    parameter int ADDR_W = reg_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    state_t state;
    logic   last_gnt;
    logic   win0;

    logic              acc_we;
    logic              acc_wr;
    logic              acc_rd;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // Requester 0 wins when alone, or on a tie when requester 1 was granted last.
    always_comb begin
        win0 = req0 & (~req1 | last_gnt);
    end

    // Requester inputs stay stable through the grant, so the access muxes them live.
    always_comb begin
        acc_we    = gnt0 ? we0    : we1;
        acc_addr  = gnt0 ? addr0  : addr1;
        acc_wdata = gnt0 ? wdata0 : wdata1;
        acc_wr    = (gnt0 | gnt1) & acc_we;
        acc_rd    = (gnt0 | gnt1) & ~acc_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state <= GRANT;
                        gnt0  <= win0;
                        gnt1  <= ~win0;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    state    <= COOL;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    busy     <= 1'b0;
                    last_gnt <= gnt1;
                    rvalid0  <= gnt0 & ~we0;
                    rvalid1  <= gnt1 & ~we1;
                end
                COOL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    reg_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_reg_file (
        .clk  (clk),
        .reset(reset),
        .we   (acc_wr),
        .re   (acc_rd),
        .addr (acc_addr),
        .wdata(acc_wdata),
        .rdata(rdata)
    );

endmodule
